exu_mem_responder: RTL and testbench
====================================

Name: exu_mem_responder

Overview:
- Data-memory responder for the EXU store/load path. EXU is the initiator and issues address/data/enable requests; this block is the responder and completes them against an internal word-addressed SRAM model.
- Uses a valid/ready request channel and a valid/ready response channel, with programmable access latency.
- Sits between EXU and the register writeback mux. Load data is returned already extended per funct3.

Parameters:
- ADDR_W, 32, request address width
- DEPTH, 1024, SRAM size in 32-bit words (power of 2)
- BASE, 32'h8000_0000, byte address of word 0
- LATENCY, 2, cycles spent in BUSY before a response is produced (0..15)

Ports:
- cpu_clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1=store, 0=load
- req_funct  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned, out-of-range, or illegal funct

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. SRAM contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/funct/addr/wdata and load cnt=LATENCY. Go to BUSY; if LATENCY==0, go directly to RESP.
  - BUSY: req_ready=0. cnt decrements each cycle. When cnt reaches 1, perform the access on that edge and go to RESP.
  - RESP: resp_valid=1 with rdata/err held stable until resp_ready. On the handshake, return to IDLE. The next request is accepted no earlier than the following cycle (no back-to-back overlap; one outstanding request maximum).
- Address checks:
  - index=(addr-BASE)>>2.
  - Out of range if addr<BASE or index>=DEPTH → err=1, no write, rdata=0.
  - Misaligned if H and addr[0]!=0, or W and addr[1:0]!=0 → err=1, no write.
  - Illegal funct (load 3/6/7, store >2) → err=1.
- Stores: the byte-lane mask is derived from funct and addr[1:0]. SB writes one lane, SH two lanes, SW all four; wdata is shifted into the selected lanes.
- Loads: select a byte or half by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend.
- resp_valid holding while resp_ready=0: outputs stay frozen and no new request is accepted.
- rst asserted mid-operation (BUSY or RESP): return to IDLE immediately and drop the response. A store already committed in BUSY stays committed; a store still pending is discarded.
- req_valid deasserted before acceptance: no effect.

Optional Feature:
- Macro EXU_MEM_RAND_DELAY_EN.
- Defined: an 8-bit LFSR (seed 8'hA5 on rst, polynomial x^8+x^6+x^5+x^4+1) advances every cycle. In IDLE, req_ready is forced low when lfsr[0]==1. On acceptance, cnt=LATENCY+lfsr[2:1].
- Undefined: no LFSR; fixed latency; req_ready=1 whenever the state is IDLE.

Decomposition:
- Shared package exu_mem_pkg holds:
  - funct3 constants: F_B=0, F_H=1, F_W=2, F_BU=4, F_HU=5
  - state enum: IDLE, BUSY, RESP
  - function lane_mask(funct, addr_lo) returning 4 bits
- One sub-module, exu_mem_align: combinational store-data shift/mask and load extract/extend. It is shared by the store and load paths and tested standalone.

Test Plan:
- LATENCY=2, SW 0x8000_0010 ← 0xDEADBEEF, then LW same address → resp_valid 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
- SB 0x8000_0011 ← 0x80, then LB → 0xFFFF_FF80; LBU → 0x0000_0080; LW → 0xDEAD80EF.
- LH 0x8000_0013 → err=1, rdata=0. SW 0x7FFF_FFFC → err=1 and memory unchanged.
- resp_ready held 0 for 5 cycles → resp_valid/rdata stable, req_ready=0 throughout. Handshake → req_ready=1 in the next cycle.
- rst pulsed while in BUSY on a SW → next cycle: IDLE, resp_valid=0. A subsequent LW returns the old word.
- With EXU_MEM_RAND_DELAY_EN, 100 random SW/LW pairs → every LW matches the scoreboard. Latency ∈ [LATENCY, LATENCY+3]+1.

Source files
------------

// File: rtl/exu_mem_responder_pkg.sv
// Shared definitions for the EXU data-memory responder: funct3 codes, FSM states
// and the byte-lane mask helper used by the store path.
package exu_mem_pkg;

  localparam logic [2:0] F_B  = 3'd0;
  localparam logic [2:0] F_H  = 3'd1;
  localparam logic [2:0] F_W  = 3'd2;
  localparam logic [2:0] F_BU = 3'd4;
  localparam logic [2:0] F_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] funct, input logic [1:0] addr_lo);
    logic [3:0] m;
    m = 4'b0000;
    case (funct)
      F_B, F_BU: m = 4'b0001 << addr_lo;
      F_H, F_HU: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      F_W:       m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  // Loads only define B/H/W/BU/HU; stores only define B/H/W.
  function automatic logic funct_illegal(input logic we, input logic [2:0] funct);
    logic bad;
    bad = 1'b0;
    if (we) begin
      bad = (funct > F_W);
    end else begin
      bad = (funct == 3'd3) || (funct >= 3'd6);
    end
    return bad;
  endfunction

endpackage

// File: rtl/exu_mem_responder_if.sv
// Request/response channel between the EXU initiator (master) and the
// data-memory responder (slave).
interface exu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/exu_mem_responder_align.sv
// Combinational lane logic: replicates store data into byte lanes with a lane
// mask, and extracts/extends load data from a memory word.
module exu_mem_align
  import exu_mem_pkg::*;
(
  input  logic [2:0]  i_funct,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rword >> {i_addr_lo, 3'b000});
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  assign o_be   = lane_mask(i_funct, i_addr_lo);

  // Replicated store data lets the lane mask alone pick the destination bytes.
  always_comb begin
    o_wdata = 32'h0000_0000;
    o_rdata = 32'h0000_0000;
    case (i_funct)
      F_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      F_W: begin
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      F_BU: begin
        o_wdata = 32'h0000_0000;
        o_rdata = {24'h00_0000, w_byte};
      end
      F_HU: begin
        o_wdata = 32'h0000_0000;
        o_rdata = {16'h0000, w_half};
      end
      default: begin
        o_wdata = 32'h0000_0000;
        o_rdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/exu_mem_responder.sv
// EXU data-memory responder: one outstanding request, programmable latency,
// word-addressed SRAM model. Optional random stalls under EXU_MEM_RAND_DELAY_EN.
module exu_mem_responder
  import exu_mem_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic      cpu_clk,
  input  logic      rst,
  exu_mem_if.slave  bus
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t            r_state;
  state_t            w_state_nx;
  logic [4:0]        r_cnt;
  logic [4:0]        w_cnt_nx;
  logic [4:0]        w_lat_ld;
  logic              w_cap;
  logic              w_do_acc;
  logic              w_req_ready;

  logic              r_we;
  logic [2:0]        r_funct;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_a_we;
  logic [2:0]        w_a_funct;
  logic [ADDR_W-1:0] w_a_addr;
  logic [31:0]       w_a_wdata;
  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_oor;
  logic              w_mis;
  logic              w_acc_err;
  logic [3:0]        w_be;
  logic [31:0]       w_wsh;
  logic [31:0]       w_ld;
  logic [31:0]       w_acc_rdata;
  logic              w_mem_we;

`ifdef EXU_MEM_RAND_DELAY_EN
  logic [7:0] r_lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR that injects stalls and extra latency.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_req_ready = (r_state == IDLE) && !r_lfsr[0];
  assign w_lat_ld    = 5'(LATENCY) + {3'b000, r_lfsr[2:1]};
`else
  assign w_req_ready = (r_state == IDLE);
  assign w_lat_ld    = 5'(LATENCY);
`endif

  // A zero-latency access happens on the accept edge, before the request is captured.
  assign w_a_we    = (r_state == IDLE) ? bus.req_we    : r_we;
  assign w_a_funct = (r_state == IDLE) ? bus.req_funct : r_funct;
  assign w_a_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_a_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

  assign w_off     = w_a_addr - BASE_A;
  assign w_idx     = w_off[IDX_W+1:2];
  assign w_oor     = (w_a_addr < BASE_A) || ((w_off >> 2) >= DEPTH_A);
  assign w_mis     = (((w_a_funct == F_H) || (w_a_funct == F_HU)) && w_a_addr[0])
                   || ((w_a_funct == F_W) && (w_a_addr[1:0] != 2'b00));
  assign w_acc_err = w_oor || w_mis || funct_illegal(w_a_we, w_a_funct);

  exu_mem_align u_align (
    .i_funct   (w_a_funct),
    .i_addr_lo (w_a_addr[1:0]),
    .i_wdata   (w_a_wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wdata   (w_wsh),
    .o_rdata   (w_ld)
  );

  assign w_acc_rdata = (w_acc_err || w_a_we) ? 32'h0000_0000 : w_ld;
  assign w_mem_we    = w_do_acc && w_a_we && !w_acc_err && !rst;

  // Next-state and counter logic for IDLE -> BUSY -> RESP.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cap      = 1'b0;
    w_do_acc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && w_req_ready) begin
          w_cap = 1'b1;
          if (w_lat_ld == 5'd0) begin
            w_do_acc   = 1'b1;
            w_state_nx = RESP;
          end else begin
            w_cnt_nx   = w_lat_ld;
            w_state_nx = BUSY;
          end
        end else begin
          w_state_nx = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt <= 5'd1) begin
          w_do_acc   = 1'b1;
          w_cnt_nx   = 5'd0;
          w_state_nx = RESP;
        end else begin
          w_cnt_nx   = r_cnt - 5'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx = RESP;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = 5'd0;
      end
    endcase
  end

  // State, captured request and response registers.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_we    <= 1'b0;
      r_funct <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_cap) begin
        r_we    <= bus.req_we;
        r_funct <= bus.req_funct;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (w_do_acc) begin
        r_rdata <= w_acc_rdata;
        r_err   <= w_acc_err;
      end
    end
  end

  // SRAM byte-lane writes; contents intentionally survive reset.
  always_ff @(posedge cpu_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_exu_mem_responder.sv
// Scoreboard bench for exu_mem_responder; build with EXU_MEM_RAND_DELAY_EN to
// exercise random stalls and latency.
module tb_exu_mem_responder;
  import exu_mem_pkg::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT_MIN = LAT + 1;
`ifdef EXU_MEM_RAND_DELAY_EN
  localparam int LAT_MAX = LAT + 4;
  localparam int N_RAND  = 100;
  localparam bit RDY_RST = 1'b0;
`else
  localparam int LAT_MAX = LAT + 1;
  localparam int N_RAND  = 30;
  localparam bit RDY_RST = 1'b1;
`endif

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic [31:0] mdl [int];

  exu_mem_if #(.ADDR_W(32)) bus ();

  exu_mem_responder #(
    .ADDR_W(32), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)
  ) dut (
    .cpu_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference memory model: returns the expected response and applies stores.
  task automatic model_apply(input logic we, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] wd, output exp_t e);
    logic [31:0] off, w;
    logic [7:0]  b;
    logic [15:0] h;
    int          lo, idx;
    logic        bad;
    off = a - BASE;
    lo  = int'(a[1:0]);
    idx = int'(off >> 2);
    bad = (a < BASE) || ((off >> 2) >= 32'(DEPTH));
    if ((f == 3'd1 || f == 3'd5) && a[0]) bad = 1'b1;
    if (f == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
    if (we ? (f > 3'd2) : (f == 3'd3 || f >= 3'd6)) bad = 1'b1;
    e.err = bad;
    e.rd  = 32'h0;
    if (!bad) begin
      w = mdl.exists(idx) ? mdl[idx] : 32'hxxxx_xxxx;
      if (we) begin
        case (f)
          3'd0:    w[8*lo +: 8]  = wd[7:0];
          3'd1:    w[8*lo +: 16] = wd[15:0];
          default: w = wd;
        endcase
        mdl[idx] = w;
      end else begin
        b = w[8*lo +: 8];
        h = (lo >= 2) ? w[31:16] : w[15:0];
        case (f)
          3'd0:    e.rd = {{24{b[7]}}, b};
          3'd4:    e.rd = {24'h0, b};
          3'd1:    e.rd = {{16{h[15]}}, h};
          3'd5:    e.rd = {16'h0, h};
          default: e.rd = w;
        endcase
      end
    end
  endtask

  // Drive one request and wait for its response; keep=1 leaves resp_ready low.
  task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep,
                        output logic [31:0] rd, output logic err, output int lat);
    int g;
    rd  = 32'h0;
    err = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_funct  = f;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    bus.resp_ready = !keep;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL req_accept_timeout: req_ready=%b, required 1 within 200 cycles", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: resp_valid=%b, required 1 within 100 cycles", bus.resp_valid);
      return;
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b, required 0", bus.resp_valid); end
    n_checks++;
    if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h, required 0", bus.resp_rdata); end
    n_checks++;
    if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b, required 0", bus.resp_err); end
    n_checks++;
    if (bus.req_ready !== RDY_RST) begin n_fail++; $display("FAIL reset_req_ready: got %b, required %b", bus.req_ready, RDY_RST); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    vec_t v[2] = '{'{1'b1, F_W, 32'h8000_0010, 32'hDEAD_BEEF},
                   '{1'b0, F_W, 32'h8000_0010, 32'h0}};
    exp_t e; logic [31:0] rd; logic er; int lat;
    foreach (v[i]) begin
      model_apply(v[i].we, v[i].f, v[i].a, v[i].wd, e);
      sb_q.push_back(e);
      do_req(v[i].we, v[i].f, v[i].a, v[i].wd, 1'b0, rd, er, lat);
      e = sb_q.pop_front();
      n_checks++;
      if (rd !== e.rd || er !== e.err) begin
        n_fail++; $display("FAIL word[%0d]: rdata=%h err=%b, required rdata=%h err=%b", i, rd, er, e.rd, e.err);
      end
      n_checks++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
        n_fail++; $display("FAIL word_latency[%0d]: got %0d, required %0d..%0d", i, lat, LAT_MIN, LAT_MAX);
      end
    end
  endtask

  task automatic test_byte_half();
    vec_t v[9] = '{'{1'b1, F_B,  32'h8000_0011, 32'h0000_0080},
                   '{1'b0, F_B,  32'h8000_0011, 32'h0},
                   '{1'b0, F_BU, 32'h8000_0011, 32'h0},
                   '{1'b0, F_W,  32'h8000_0010, 32'h0},
                   '{1'b1, F_H,  32'h8000_0016, 32'h5555_9A34},
                   '{1'b1, F_W,  32'h8000_0014, 32'h0102_0304},
                   '{1'b1, F_H,  32'h8000_0016, 32'h0000_9A34},
                   '{1'b0, F_H,  32'h8000_0016, 32'h0},
                   '{1'b0, F_HU, 32'h8000_0016, 32'h0}};
    exp_t e; logic [31:0] rd; logic er; int lat;
    foreach (v[i]) begin
      model_apply(v[i].we, v[i].f, v[i].a, v[i].wd, e);
      sb_q.push_back(e);
      do_req(v[i].we, v[i].f, v[i].a, v[i].wd, 1'b0, rd, er, lat);
      e = sb_q.pop_front();
      n_checks++;
      if (rd !== e.rd || er !== e.err) begin
        n_fail++; $display("FAIL byte_half[%0d]: rdata=%h err=%b, required rdata=%h err=%b", i, rd, er, e.rd, e.err);
      end
    end
    foreach (v[i]) begin
      if (i < 4) begin
        model_apply(1'b0, (i == 3) ? F_W : ((i == 2) ? F_B : F_BU), 32'h8000_0014 + 32'(i), 32'h0, e);
        sb_q.push_back(e);
        do_req(1'b0, (i == 3) ? F_W : ((i == 2) ? F_B : F_BU), 32'h8000_0014 + 32'(i), 32'h0, 1'b0, rd, er, lat);
        e = sb_q.pop_front();
        n_checks++;
        if (rd !== e.rd || er !== e.err) begin
          n_fail++; $display("FAIL byte_lane[%0d]: rdata=%h err=%b, required rdata=%h err=%b", i, rd, er, e.rd, e.err);
        end
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[10] = '{'{1'b1, F_W,  32'h8000_0FFC, 32'h1122_3344},
                    '{1'b0, F_H,  32'h8000_0013, 32'h0},
                    '{1'b1, F_W,  32'h7FFF_FFFC, 32'hBAD0_BAD0},
                    '{1'b0, F_W,  32'h8000_0FFC, 32'h0},
                    '{1'b0, F_W,  32'h8000_1000, 32'h0},
                    '{1'b0, F_W,  32'h8000_0012, 32'h0},
                    '{1'b0, 3'd3, 32'h8000_0010, 32'h0},
                    '{1'b0, 3'd6, 32'h8000_0010, 32'h0},
                    '{1'b1, 3'd4, 32'h8000_0010, 32'hFFFF_FFFF},
                    '{1'b0, F_W,  32'h8000_0010, 32'h0}};
    exp_t e; logic [31:0] rd; logic er; int lat;
    foreach (v[i]) begin
      model_apply(v[i].we, v[i].f, v[i].a, v[i].wd, e);
      sb_q.push_back(e);
      do_req(v[i].we, v[i].f, v[i].a, v[i].wd, 1'b0, rd, er, lat);
      e = sb_q.pop_front();
      n_checks++;
      if (rd !== e.rd || er !== e.err) begin
        n_fail++; $display("FAIL errors[%0d]: rdata=%h err=%b, required rdata=%h err=%b", i, rd, er, e.rd, e.err);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic [31:0] rd; logic er; int lat;
    model_apply(1'b0, F_W, 32'h8000_0010, 32'h0, e);
    sb_q.push_back(e);
    do_req(1'b0, F_W, 32'h8000_0010, 32'h0, 1'b1, rd, er, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (rd !== e.rd || er !== e.err) begin
      n_fail++; $display("FAIL bp_first: rdata=%h err=%b, required rdata=%h err=%b", rd, er, e.rd, e.err);
    end
    for (int c = 0; c < 5; c++) begin
      bus.req_we    = 1'b1;
      bus.req_funct = F_W;
      bus.req_addr  = 32'h8000_0010;
      bus.req_wdata = 32'h0000_0000;
      bus.req_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rd || bus.resp_err !== e.err || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                 c, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, e.rd, e.err);
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b, required 0", bus.resp_valid); end
`ifndef EXU_MEM_RAND_DELAY_EN
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b, required 1", bus.req_ready); end
`endif
    model_apply(1'b0, F_W, 32'h8000_0010, 32'h0, e);
    sb_q.push_back(e);
    do_req(1'b0, F_W, 32'h8000_0010, 32'h0, 1'b0, rd, er, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (rd !== e.rd || er !== e.err) begin
      n_fail++; $display("FAIL bp_no_write: rdata=%h err=%b, required rdata=%h err=%b", rd, er, e.rd, e.err);
    end
  endtask

  task automatic test_reset_busy();
    exp_t e; logic [31:0] rd; logic er; int lat, g, bad;
    model_apply(1'b1, F_W, 32'h8000_0020, 32'hCAFE_F00D, e);
    sb_q.push_back(e);
    do_req(1'b1, F_W, 32'h8000_0020, 32'hCAFE_F00D, 1'b0, rd, er, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (rd !== e.rd || er !== e.err) begin
      n_fail++; $display("FAIL rstbusy_pre: rdata=%h err=%b, required rdata=%h err=%b", rd, er, e.rd, e.err);
    end
    @(negedge clk);
    bus.req_we    = 1'b1;
    bus.req_funct = F_W;
    bus.req_addr  = 32'h8000_0020;
    bus.req_wdata = 32'h0BAD_BEEF;
    bus.req_valid = 1'b1;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (g >= 200) begin n_fail++; $display("FAIL rstbusy_accept: req_ready=%b, required 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== RDY_RST) begin
      n_fail++;
      $display("FAIL rstbusy_idle: resp_valid=%b req_ready=%b, required 0 %b", bus.resp_valid, bus.req_ready, RDY_RST);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rstbusy_dropped: resp_valid high %0d cycles, required 0", bad); end
    model_apply(1'b0, F_W, 32'h8000_0020, 32'h0, e);
    sb_q.push_back(e);
    do_req(1'b0, F_W, 32'h8000_0020, 32'h0, 1'b0, rd, er, lat);
    e = sb_q.pop_front();
    n_checks++;
    if (rd !== e.rd || er !== e.err) begin
      n_fail++; $display("FAIL rstbusy_old_word: rdata=%h err=%b, required rdata=%h err=%b", rd, er, e.rd, e.err);
    end
  endtask

  task automatic test_random();
    exp_t e; logic [31:0] rd, a, d; logic er; int lat;
    for (int i = 0; i < N_RAND; i++) begin
      a = BASE + (32'($urandom_range(256, 511)) << 2);
      d = $urandom;
      for (int k = 0; k < 2; k++) begin
        model_apply(k == 0, F_W, a, d, e);
        sb_q.push_back(e);
        do_req(k == 0, F_W, a, d, 1'b0, rd, er, lat);
        e = sb_q.pop_front();
        n_checks++;
        if (rd !== e.rd || er !== e.err) begin
          n_fail++; $display("FAIL random[%0d.%0d]: rdata=%h err=%b, required rdata=%h err=%b", i, k, rd, er, e.rd, e.err);
        end
        n_checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
          n_fail++; $display("FAIL random_latency[%0d.%0d]: got %0d, required %0d..%0d", i, k, lat, LAT_MIN, LAT_MAX);
        end
      end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct  = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
